pipe_adder: RTL

Parametrised, pipelined, segmented adder with a valid/ready handshake, per-transaction wrap or saturate mode, and a saturating overflow counter. It replaces the single-cycle combinational 4-bit adder wherever operands arrive as a stream and timing closure requires the carry chain to be split across register stages. It sits between an operand producer and a result consumer that can each stall independently.

---
 rtl/pipe_adder_pkg.sv | 22 ++
 rtl/pipe_adder_assert.sv | 72 +++++++
 rtl/pipe_adder_seg.sv | 78 +++++++
 rtl/pipe_adder.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
//   Shared types and helpers for the segmented pipelined adder.
//   add_mode_e : per-transaction result mode (wrap or unsigned saturate).
//   sat_value  : all-ones constant of a given width, used as the saturated y.
package pipe_adder_pkg;

   typedef enum logic {ADD_WRAP = 1'b0, ADD_SAT = 1'b1} add_mode_e;

   // Widest operand the saturation helper can describe.
   localparam int MAX_WIDTH = 64;

   // Returns {1'b0, {width{1'b1}}} zero-extended to MAX_WIDTH+1 bits.
   function automatic logic [MAX_WIDTH:0] sat_value(input int width);
      logic [MAX_WIDTH:0] v;
      v = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/pipe_adder_assert.sv
// pipe_adder_assert
//   Protocol checker for pipe_adder, attached with bind. Observes the ports
//   only and checks:
//     - y/ovf/out_valid hold while a result is stalled
//     - no result is presented without an outstanding input transfer
//     - out_valid follows the input transfers exactly STAGES advances later
//     - ovf_cnt never decreases except after a clear
//   Ports mirror the pipe_adder port names.
module pipe_adder_assert #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 8
) (
   input logic             clk,
   input logic             rst,
   input logic             in_valid,
   input logic             in_ready,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH:0]   y,
   input logic             ovf,
   input logic [CNT_W-1:0] ovf_cnt,
   input logic             cnt_clr
);

   logic              in_xfer;
   logic              out_xfer;
   logic              adv;
   logic [STAGES-1:0] ref_valid_reg;
   logic [31:0]       in_flight_reg;
   logic              stall_reg;
   logic [WIDTH:0]    y_prev_reg;
   logic              ovf_prev_reg;
   logic              cnt_seen_reg;
   logic              clr_prev_reg;
   logic [CNT_W-1:0]  cnt_prev_reg;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign adv      = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_valid_reg <= '0;
         in_flight_reg <= '0;
         stall_reg     <= 1'b0;
         cnt_seen_reg  <= 1'b0;
      end else begin
         if (adv) ref_valid_reg <= (ref_valid_reg << 1) | STAGES'(in_valid);
         in_flight_reg <= in_flight_reg + 32'(in_xfer) - 32'(out_xfer);
         stall_reg     <= out_valid && !out_ready;
         cnt_seen_reg  <= 1'b1;
      end
      y_prev_reg   <= y;
      ovf_prev_reg <= ovf;
      clr_prev_reg <= cnt_clr;
      cnt_prev_reg <= ovf_cnt;
   end

   a_hold: assert property (@(posedge clk) disable iff (rst)
      stall_reg |-> (out_valid && y == y_prev_reg && ovf == ovf_prev_reg));

   a_origin: assert property (@(posedge clk) disable iff (rst)
      out_valid |-> (in_flight_reg != 32'd0));

   a_latency: assert property (@(posedge clk) disable iff (rst)
      out_valid == ref_valid_reg[STAGES-1]);

   a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
      (cnt_seen_reg && !clr_prev_reg) |-> (ovf_cnt >= cnt_prev_reg));

endmodule

// File: rtl/pipe_adder_seg.sv
// pipe_adder_seg
//   One pipeline stage of the segmented adder. Adds slice IDX of the operands
//   plus the incoming carry, merges the slice result into the running sum and
//   registers everything (valid, mode, operands, partial sum, carry) when en=1.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     en                  global pipeline advance enable
//     valid/mode/a/b/sum/carry          payload from the previous stage
//     fwd_valid/fwd_mode/fwd_a/fwd_b/fwd_sum/fwd_carry  registered payload
module pipe_adder_seg
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG   = 4,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid,
   input  add_mode_e        mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] sum,
   input  logic             carry,
   output logic             fwd_valid,
   output add_mode_e        fwd_mode,
   output logic [WIDTH-1:0] fwd_a,
   output logic [WIDTH-1:0] fwd_b,
   output logic [WIDTH-1:0] fwd_sum,
   output logic             fwd_carry
);

   logic [SEG:0]     slice_sum;
   logic [WIDTH-1:0] sum_next;

   logic             valid_reg;
   add_mode_e        mode_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;

   always_comb begin
      slice_sum = {1'b0, a[IDX*SEG +: SEG]} + {1'b0, b[IDX*SEG +: SEG]}
                + {{SEG{1'b0}}, carry};
      // Lower slices are already final; upper slices are still zero.
      sum_next = sum;
      sum_next[IDX*SEG +: SEG] = slice_sum[SEG-1:0];
   end

   // Payload is reset too so the last stage presents y=0, ovf=0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         mode_reg  <= ADD_WRAP;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (en) begin
         valid_reg <= valid;
         mode_reg  <= mode;
         a_reg     <= a;
         b_reg     <= b;
         sum_reg   <= sum_next;
         carry_reg <= slice_sum[SEG];
      end
   end

   assign fwd_valid = valid_reg;
   assign fwd_mode  = mode_reg;
   assign fwd_a     = a_reg;
   assign fwd_b     = b_reg;
   assign fwd_sum   = sum_reg;
   assign fwd_carry = carry_reg;

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
//   Pipelined segmented adder, S = a + b + cin split into STAGES slices of
//   WIDTH/STAGES bits, with valid/ready handshake, per-transaction wrap or
//   saturate mode and a saturating overflow counter.
//   WIDTH must be a multiple of STAGES and no larger than MAX_WIDTH.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid, in_ready   operand handshake (in_ready is combinational)
//     a, b, cin, sat       operands, carry-in, mode (1 = saturate)
//     out_valid, out_ready result handshake
//     y, ovf               result (WIDTH+1 bits) and carry-out of the sum
//     ovf_cnt, cnt_clr     delivered-overflow counter and its clear
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   y,
   output logic             ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic             cnt_clr
);

   localparam int                 SEG      = WIDTH / STAGES;
   localparam logic [MAX_WIDTH:0] SAT_FULL = sat_value(WIDTH);
   localparam logic [WIDTH:0]     SAT_Y    = SAT_FULL[WIDTH:0];
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   // Index 0 is the input side; index k+1 is the register of stage k.
   logic             stage_valid [STAGES+1];
   add_mode_e        stage_mode  [STAGES+1];
   logic [WIDTH-1:0] stage_a     [STAGES+1];
   logic [WIDTH-1:0] stage_b     [STAGES+1];
   logic [WIDTH-1:0] stage_sum   [STAGES+1];
   logic             stage_carry [STAGES+1];

   logic             en;
   logic [CNT_W-1:0] ovf_cnt_reg;

   // All stages move together; the pipe freezes only when the result at the
   // output is being held for the consumer.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   assign stage_valid[0] = in_valid;
   assign stage_mode[0]  = sat ? ADD_SAT : ADD_WRAP;
   assign stage_a[0]     = a;
   assign stage_b[0]     = b;
   assign stage_sum[0]   = '0;
   assign stage_carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         pipe_adder_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (gi)
         ) u_seg (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .valid     (stage_valid[gi]),
            .mode      (stage_mode[gi]),
            .a         (stage_a[gi]),
            .b         (stage_b[gi]),
            .sum       (stage_sum[gi]),
            .carry     (stage_carry[gi]),
            .fwd_valid (stage_valid[gi+1]),
            .fwd_mode  (stage_mode[gi+1]),
            .fwd_a     (stage_a[gi+1]),
            .fwd_b     (stage_b[gi+1]),
            .fwd_sum   (stage_sum[gi+1]),
            .fwd_carry (stage_carry[gi+1])
         );
      end
   endgenerate

   // Outputs are decoded straight from the last stage registers, so they are
   // stable while the pipe is frozen and zero after reset.
   assign out_valid = stage_valid[STAGES];
   assign ovf       = stage_carry[STAGES];
   assign y         = (stage_mode[STAGES] == ADD_SAT && stage_carry[STAGES])
                    ? SAT_Y : {stage_carry[STAGES], stage_sum[STAGES]};

   // Clear beats a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt_reg <= '0;
      end else if (cnt_clr) begin
         ovf_cnt_reg <= '0;
      end else if (out_valid && out_ready && ovf && ovf_cnt_reg != CNT_MAX) begin
         ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      end
   end

   assign ovf_cnt = ovf_cnt_reg;

endmodule
